// File: rtl/param_reservation_station_if.sv
// Dispatch, wakeup and issue bundle for the reservation station.
// master drives dispatch/wakeup/fu_ready; slave is the station.
interface param_reservation_station_if #(
  parameter int NUM_FU   = 3,
  parameter int NUM_WAKE = 2,
  parameter int TAG_W    = 6,
  parameter int DATA_W   = 32,
  parameter int ROB_W    = 6
);
  logic                       disp_valid;
  logic                       disp_ready;
  logic [TAG_W-1:0]           disp_rd_tag;
  logic [TAG_W-1:0]           disp_rs1_tag;
  logic [TAG_W-1:0]           disp_rs2_tag;
  logic                       disp_rs1_rdy;
  logic                       disp_rs2_rdy;
  logic [DATA_W-1:0]          disp_rs1_val;
  logic [DATA_W-1:0]          disp_rs2_val;
  logic [DATA_W-1:0]          disp_imm;
  logic [3:0]                 disp_alu_ctrl;
  logic                       disp_alusrc;
  logic                       disp_is_ls;
  logic [ROB_W-1:0]           disp_rob;
  logic [NUM_FU-1:0]          disp_fu_mask;

  logic [NUM_WAKE-1:0]        wake_valid;
  logic [NUM_WAKE*TAG_W-1:0]  wake_tag;
  logic [NUM_WAKE*DATA_W-1:0] wake_val;

  logic [NUM_FU-1:0]          fu_ready;
  logic [NUM_FU-1:0]          issue_valid;
  logic [NUM_FU*TAG_W-1:0]    issue_rd_tag;
  logic [NUM_FU*DATA_W-1:0]   issue_rs1_val;
  logic [NUM_FU*DATA_W-1:0]   issue_rs2_val;
  logic [NUM_FU*DATA_W-1:0]   issue_imm;
  logic [NUM_FU*4-1:0]        issue_alu_ctrl;
  logic [NUM_FU-1:0]          issue_alusrc;
  logic [NUM_FU-1:0]          issue_is_ls;
  logic [NUM_FU*ROB_W-1:0]    issue_rob;

  modport master (
    output disp_valid, disp_rd_tag,
    output disp_rs1_tag, disp_rs2_tag,
    output disp_rs1_rdy, disp_rs2_rdy,
    output disp_rs1_val, disp_rs2_val,
    output disp_imm, disp_alu_ctrl,
    output disp_alusrc, disp_is_ls,
    output disp_rob, disp_fu_mask,
    output wake_valid, wake_tag, wake_val,
    output fu_ready,
    input  disp_ready,
    input  issue_valid, issue_rd_tag,
    input  issue_rs1_val, issue_rs2_val,
    input  issue_imm, issue_alu_ctrl,
    input  issue_alusrc, issue_is_ls,
    input  issue_rob
  );

  modport slave (
    input  disp_valid, disp_rd_tag,
    input  disp_rs1_tag, disp_rs2_tag,
    input  disp_rs1_rdy, disp_rs2_rdy,
    input  disp_rs1_val, disp_rs2_val,
    input  disp_imm, disp_alu_ctrl,
    input  disp_alusrc, disp_is_ls,
    input  disp_rob, disp_fu_mask,
    input  wake_valid, wake_tag, wake_val,
    input  fu_ready,
    output disp_ready,
    output issue_valid, issue_rd_tag,
    output issue_rs1_val, issue_rs2_val,
    output issue_imm, issue_alu_ctrl,
    output issue_alusrc, issue_is_ls,
    output issue_rob
  );
endinterface

// File: rtl/param_reservation_station.sv
// Unified reservation station: CDB wakeup, age-matrix oldest-first
// select across NUM_FU lanes, registered issue, flush and backpressure.
module param_reservation_station #(
  parameter int RS_DEPTH = 16,
  parameter int NUM_FU   = 3,
  parameter int NUM_WAKE = 2,
  parameter int TAG_W    = 6,
  parameter int DATA_W   = 32,
  parameter int ROB_W    = 6,
  localparam int CNT_W   = $clog2(RS_DEPTH+1),
  localparam int IDX_W   = $clog2(RS_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  param_reservation_station_if.slave bus,
  output logic [CNT_W-1:0] count
);

  logic [RS_DEPTH-1:0] r_valid;
  logic [RS_DEPTH-1:0] r_rs1_rdy;
  logic [RS_DEPTH-1:0] r_rs2_rdy;
  logic [RS_DEPTH-1:0] r_alusrc;
  logic [RS_DEPTH-1:0] r_is_ls;
  logic [TAG_W-1:0]    r_rd_tag  [RS_DEPTH];
  logic [TAG_W-1:0]    r_rs1_tag [RS_DEPTH];
  logic [TAG_W-1:0]    r_rs2_tag [RS_DEPTH];
  logic [DATA_W-1:0]   r_rs1_val [RS_DEPTH];
  logic [DATA_W-1:0]   r_rs2_val [RS_DEPTH];
  logic [DATA_W-1:0]   r_imm     [RS_DEPTH];
  logic [3:0]          r_alu     [RS_DEPTH];
  logic [ROB_W-1:0]    r_rob     [RS_DEPTH];
  logic [NUM_FU-1:0]   r_mask    [RS_DEPTH];
  // r_older[i][j]: entry i was dispatched before entry j
  logic [RS_DEPTH-1:0] r_older   [RS_DEPTH];
  logic [CNT_W-1:0]    r_count;

  logic [NUM_FU-1:0]        r_iss_valid;
  logic [NUM_FU*TAG_W-1:0]  r_iss_rd_tag;
  logic [NUM_FU*DATA_W-1:0] r_iss_rs1;
  logic [NUM_FU*DATA_W-1:0] r_iss_rs2;
  logic [NUM_FU*DATA_W-1:0] r_iss_imm;
  logic [NUM_FU*4-1:0]      r_iss_alu;
  logic [NUM_FU-1:0]        r_iss_alusrc;
  logic [NUM_FU-1:0]        r_iss_is_ls;
  logic [NUM_FU*ROB_W-1:0]  r_iss_rob;

  logic                w_disp_ready;
  logic                w_accept;
  logic [IDX_W-1:0]    w_free_idx;
  logic [NUM_FU-1:0]   w_disp_mask;
  logic [DATA_W:0]     w_byp1;
  logic [DATA_W:0]     w_byp2;
  logic [RS_DEPTH-1:0] w_wk1_hit;
  logic [RS_DEPTH-1:0] w_wk2_hit;
  logic [DATA_W-1:0]   w_wk1_val [RS_DEPTH];
  logic [DATA_W-1:0]   w_wk2_val [RS_DEPTH];
  logic [RS_DEPTH-1:0] w_elig;
  logic [NUM_FU-1:0]   w_grant;
  logic [IDX_W-1:0]    w_pick [NUM_FU];
  logic [CNT_W-1:0]    w_n_iss;

  // Returns {hit, value}; the lowest-index matching port wins.
  function automatic logic [DATA_W:0] f_wake(
    input logic [TAG_W-1:0]           tag,
    input logic [NUM_WAKE-1:0]        vld,
    input logic [NUM_WAKE*TAG_W-1:0]  tags,
    input logic [NUM_WAKE*DATA_W-1:0] vals
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int p = NUM_WAKE-1; p >= 0; p--) begin
      if (vld[p] && tags[p*TAG_W +: TAG_W] == tag)
        res = {1'b1, vals[p*DATA_W +: DATA_W]};
    end
    return res;
  endfunction

  assign w_disp_ready = r_count < CNT_W'(RS_DEPTH);
  assign w_accept     = bus.disp_valid && w_disp_ready && !flush;
  assign w_disp_mask  = (bus.disp_fu_mask == '0) ?
                        '1 : bus.disp_fu_mask;
  assign w_elig       = r_valid & r_rs1_rdy & r_rs2_rdy;

  always_comb begin
    w_free_idx = '0;
    for (int i = RS_DEPTH-1; i >= 0; i--)
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
  end

  always_comb begin
    w_byp1 = f_wake(bus.disp_rs1_tag, bus.wake_valid,
                    bus.wake_tag, bus.wake_val);
    w_byp2 = f_wake(bus.disp_rs2_tag, bus.wake_valid,
                    bus.wake_tag, bus.wake_val);
    for (int i = 0; i < RS_DEPTH; i++) begin
      {w_wk1_hit[i], w_wk1_val[i]} =
        f_wake(r_rs1_tag[i], bus.wake_valid,
               bus.wake_tag, bus.wake_val);
      {w_wk2_hit[i], w_wk2_val[i]} =
        f_wake(r_rs2_tag[i], bus.wake_valid,
               bus.wake_tag, bus.wake_val);
    end
  end

  always_comb begin : p_select
    logic [RS_DEPTH-1:0] w_claim;
    logic [RS_DEPTH-1:0] w_cand;
    logic [RS_DEPTH-1:0] w_old;
    logic                w_blk;
    w_claim = '0;
    w_grant = '0;
    w_n_iss = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      w_pick[f] = '0;
      for (int i = 0; i < RS_DEPTH; i++)
        w_cand[i] = w_elig[i] & r_mask[i][f] & ~w_claim[i];
      for (int i = 0; i < RS_DEPTH; i++) begin
        w_blk = 1'b0;
        for (int j = 0; j < RS_DEPTH; j++)
          w_blk = w_blk | (w_cand[j] & r_older[j][i]);
        w_old[i] = w_cand[i] & ~w_blk;
      end
      for (int i = 0; i < RS_DEPTH; i++)
        if (w_old[i]) w_pick[f] = IDX_W'(i);
      if (bus.fu_ready[f] && (|w_cand)) begin
        w_grant[f]         = 1'b1;
        w_claim[w_pick[f]] = 1'b1;
        w_n_iss            = w_n_iss + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= '0;
      r_rs1_rdy    <= '0;
      r_rs2_rdy    <= '0;
      r_count      <= '0;
      for (int i = 0; i < RS_DEPTH; i++)
        r_older[i] <= '0;
      r_iss_valid  <= '0;
      r_iss_rd_tag <= '0;
      r_iss_rs1    <= '0;
      r_iss_rs2    <= '0;
      r_iss_imm    <= '0;
      r_iss_alu    <= '0;
      r_iss_alusrc <= '0;
      r_iss_is_ls  <= '0;
      r_iss_rob    <= '0;
    end else if (flush) begin
      r_valid     <= '0;
      r_count     <= '0;
      r_iss_valid <= '0;
    end else begin
      r_iss_valid <= w_grant;
      r_count     <= r_count + CNT_W'(w_accept) - w_n_iss;
      for (int f = 0; f < NUM_FU; f++) begin
        if (w_grant[f]) begin
          r_valid[w_pick[f]] <= 1'b0;
          r_iss_rd_tag[f*TAG_W +: TAG_W]   <= r_rd_tag[w_pick[f]];
          r_iss_rs1[f*DATA_W +: DATA_W]    <= r_rs1_val[w_pick[f]];
          r_iss_rs2[f*DATA_W +: DATA_W]    <= r_rs2_val[w_pick[f]];
          r_iss_imm[f*DATA_W +: DATA_W]    <= r_imm[w_pick[f]];
          r_iss_alu[f*4 +: 4]              <= r_alu[w_pick[f]];
          r_iss_alusrc[f]                  <= r_alusrc[w_pick[f]];
          r_iss_is_ls[f]                   <= r_is_ls[w_pick[f]];
          r_iss_rob[f*ROB_W +: ROB_W]      <= r_rob[w_pick[f]];
        end
      end
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (r_valid[i] && !r_rs1_rdy[i] && w_wk1_hit[i]) begin
          r_rs1_rdy[i] <= 1'b1;
          r_rs1_val[i] <= w_wk1_val[i];
        end
        if (r_valid[i] && !r_rs2_rdy[i] && w_wk2_hit[i]) begin
          r_rs2_rdy[i] <= 1'b1;
          r_rs2_val[i] <= w_wk2_val[i];
        end
      end
      if (w_accept) begin
        r_valid[w_free_idx]   <= 1'b1;
        r_rd_tag[w_free_idx]  <= bus.disp_rd_tag;
        r_rs1_tag[w_free_idx] <= bus.disp_rs1_tag;
        r_rs2_tag[w_free_idx] <= bus.disp_rs2_tag;
        r_rs1_rdy[w_free_idx] <= bus.disp_rs1_rdy | w_byp1[DATA_W];
        r_rs2_rdy[w_free_idx] <= bus.disp_rs2_rdy | w_byp2[DATA_W];
        r_rs1_val[w_free_idx] <= bus.disp_rs1_rdy ?
                                 bus.disp_rs1_val : w_byp1[DATA_W-1:0];
        r_rs2_val[w_free_idx] <= bus.disp_rs2_rdy ?
                                 bus.disp_rs2_val : w_byp2[DATA_W-1:0];
        r_imm[w_free_idx]     <= bus.disp_imm;
        r_alu[w_free_idx]     <= bus.disp_alu_ctrl;
        r_alusrc[w_free_idx]  <= bus.disp_alusrc;
        r_is_ls[w_free_idx]   <= bus.disp_is_ls;
        r_rob[w_free_idx]     <= bus.disp_rob;
        r_mask[w_free_idx]    <= w_disp_mask;
        // New entry is younger than every other slot.
        for (int j = 0; j < RS_DEPTH; j++)
          r_older[j][w_free_idx] <= 1'b1;
        r_older[w_free_idx] <= '0;
      end
    end
  end

  assign bus.disp_ready     = w_disp_ready;
  assign bus.issue_valid    = r_iss_valid;
  assign bus.issue_rd_tag   = r_iss_rd_tag;
  assign bus.issue_rs1_val  = r_iss_rs1;
  assign bus.issue_rs2_val  = r_iss_rs2;
  assign bus.issue_imm      = r_iss_imm;
  assign bus.issue_alu_ctrl = r_iss_alu;
  assign bus.issue_alusrc   = r_iss_alusrc;
  assign bus.issue_is_ls    = r_iss_is_ls;
  assign bus.issue_rob      = r_iss_rob;
  assign count              = r_count;

endmodule

// File: tb/tb_param_reservation_station.sv
// Directed bench for param_reservation_station: dispatch, wakeup,
// bypass, age order, fu masks, full/backpressure, flush and reset.
module tb_param_reservation_station;
  localparam int D  = 16;
  localparam int F  = 3;
  localparam int NW = 2;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int RW = 6;
  localparam int CW = $clog2(D+1);

  logic          clk;
  logic          reset;
  logic          flush;
  logic [CW-1:0] count;
  int            total;
  int            bad;

  param_reservation_station_if #(
    .NUM_FU(F), .NUM_WAKE(NW), .TAG_W(TW),
    .DATA_W(DW), .ROB_W(RW)
  ) bus ();

  param_reservation_station #(
    .RS_DEPTH(D), .NUM_FU(F), .NUM_WAKE(NW),
    .TAG_W(TW), .DATA_W(DW), .ROB_W(RW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .bus(bus),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
  endtask

  task automatic nowake();
    bus.wake_valid = '0;
    bus.wake_tag   = '0;
    bus.wake_val   = '0;
  endtask

  task automatic disp(input logic [RW-1:0] rob,
                      input logic [TW-1:0] t1, input logic r1,
                      input logic [DW-1:0] v1,
                      input logic [TW-1:0] t2, input logic r2,
                      input logic [DW-1:0] v2,
                      input logic [F-1:0]  m);
    bus.disp_valid    = 1'b1;
    bus.disp_rob      = rob;
    bus.disp_rd_tag   = TW'(rob);
    bus.disp_rs1_tag  = t1;
    bus.disp_rs1_rdy  = r1;
    bus.disp_rs1_val  = v1;
    bus.disp_rs2_tag  = t2;
    bus.disp_rs2_rdy  = r2;
    bus.disp_rs2_val  = v2;
    bus.disp_imm      = 32'h100 + DW'(rob);
    bus.disp_alu_ctrl = 4'h3;
    bus.disp_alusrc   = 1'b0;
    bus.disp_is_ls    = 1'b0;
    bus.disp_fu_mask  = m;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    flush = 1'b0;
    bus.fu_ready = '0;
    disp('0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    idle();
    nowake();
    tick();
    tick();
    reset = 1'b0;

    chk("rst_count", 64'(count), 0);
    chk("rst_ready", 64'(bus.disp_ready), 1);
    chk("rst_ivalid", 64'(bus.issue_valid), 0);
    chk("rst_rob", 64'(bus.issue_rob), 0);

    // single ready op on lane 0
    bus.fu_ready = 3'b111;
    disp(6'd1, 6'd0, 1'b1, 32'h11, 6'd0, 1'b1, 32'h22, 3'b001);
    tick();
    idle();
    chk("t2_count1", 64'(count), 1);
    chk("t2_noiss", 64'(bus.issue_valid), 0);
    tick();
    chk("t2_iv", 64'(bus.issue_valid), 3'b001);
    chk("t2_rob", 64'(bus.issue_rob[5:0]), 1);
    chk("t2_rs1", 64'(bus.issue_rs1_val[31:0]), 32'h11);
    chk("t2_imm", 64'(bus.issue_imm[31:0]), 32'h101);
    chk("t2_count0", 64'(count), 0);
    tick();
    chk("t2_pulse", 64'(bus.issue_valid), 0);
    chk("t2_hold", 64'(bus.issue_rob[5:0]), 1);

    // younger ready op overtakes an older waiting op
    bus.fu_ready = 3'b001;
    disp(6'd2, 6'd5, 1'b0, 32'h0, 6'd0, 1'b1, 32'h33, 3'b001);
    tick();
    disp(6'd3, 6'd0, 1'b1, 32'h44, 6'd0, 1'b1, 32'h55, 3'b001);
    tick();
    idle();
    tick();
    chk("t3_b_iv", 64'(bus.issue_valid), 3'b001);
    chk("t3_b_rob", 64'(bus.issue_rob[5:0]), 3);
    chk("t3_count", 64'(count), 1);
    tick();
    chk("t3_wait", 64'(bus.issue_valid), 0);
    bus.wake_valid        = 2'b10;
    bus.wake_tag[TW +: TW] = 6'd5;
    bus.wake_val[DW +: DW] = 32'hDEAD;
    tick();
    nowake();
    chk("t3_notyet", 64'(bus.issue_valid), 0);
    tick();
    chk("t3_a_iv", 64'(bus.issue_valid), 3'b001);
    chk("t3_a_rob", 64'(bus.issue_rob[5:0]), 2);
    chk("t3_a_rs1", 64'(bus.issue_rs1_val[31:0]), 32'hDEAD);
    chk("t3_a_rs2", 64'(bus.issue_rs2_val[31:0]), 32'h33);

    // same tag on both ports: port 0 wins; mask steers to lane 2
    bus.fu_ready = 3'b111;
    disp(6'd4, 6'd12, 1'b0, 32'h0, 6'd0, 1'b1, 32'h1, 3'b100);
    tick();
    idle();
    bus.wake_valid = 2'b11;
    bus.wake_tag   = {6'd12, 6'd12};
    bus.wake_val   = {32'hBBBB, 32'hAAAA};
    tick();
    nowake();
    tick();
    chk("pri_iv", 64'(bus.issue_valid), 3'b100);
    chk("pri_rob", 64'(bus.issue_rob[17:12]), 4);
    chk("pri_rs1", 64'(bus.issue_rs1_val[95:64]), 32'hAAAA);

    // dispatch-cycle wakeup bypass on rs2, lane 1
    disp(6'd5, 6'd0, 1'b1, 32'h66, 6'd9, 1'b0, 32'h0, 3'b010);
    bus.wake_valid          = 2'b01;
    bus.wake_tag[0 +: TW]   = 6'd9;
    bus.wake_val[0 +: DW]   = 32'd7;
    tick();
    idle();
    nowake();
    tick();
    chk("byp_iv", 64'(bus.issue_valid), 3'b010);
    chk("byp_rob", 64'(bus.issue_rob[11:6]), 5);
    chk("byp_rs2", 64'(bus.issue_rs2_val[63:32]), 7);

    // fill to full, overflow attempt ignored
    bus.fu_ready = 3'b000;
    for (int i = 0; i < D; i++) begin
      disp(RW'(16 + i), 6'd0, 1'b1, 32'(i),
           6'd0, 1'b1, 32'(i), 3'b000);
      tick();
    end
    idle();
    chk("full_count", 64'(count), 16);
    chk("full_ready", 64'(bus.disp_ready), 0);
    disp(6'd40, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0, 3'b000);
    tick();
    idle();
    chk("full_ign", 64'(count), 16);
    chk("full_noiss", 64'(bus.issue_valid), 0);
    bus.fu_ready = 3'b111;
    tick();
    bus.fu_ready = 3'b000;
    chk("drain_iv", 64'(bus.issue_valid), 3'b111);
    chk("drain_rob", 64'(bus.issue_rob), {6'd18, 6'd17, 6'd16});
    chk("drain_count", 64'(count), 13);
    chk("drain_ready", 64'(bus.disp_ready), 1);

    // reused slot 0 must be youngest
    disp(6'd50, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0, 3'b001);
    tick();
    idle();
    chk("age_count", 64'(count), 14);
    bus.fu_ready = 3'b001;
    tick();
    bus.fu_ready = 3'b000;
    chk("age_iv", 64'(bus.issue_valid), 3'b001);
    chk("age_rob", 64'(bus.issue_rob[5:0]), 19);
    chk("age_count2", 64'(count), 13);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl1_count", 64'(count), 0);
    chk("fl1_ready", 64'(bus.disp_ready), 1);

    // eight held entries, flush beats dispatch and select
    for (int i = 0; i < 8; i++) begin
      disp(RW'(60 + i), 6'd0, 1'b1, 32'h0,
           6'd0, 1'b1, 32'h0, 3'b111);
      tick();
    end
    idle();
    chk("fl2_pre", 64'(count), 8);
    flush = 1'b1;
    bus.fu_ready = 3'b111;
    disp(6'd9, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0, 3'b111);
    tick();
    flush = 1'b0;
    idle();
    chk("fl2_count", 64'(count), 0);
    chk("fl2_iv", 64'(bus.issue_valid), 0);
    tick();
    chk("fl2_iv2", 64'(bus.issue_valid), 0);
    chk("fl2_count2", 64'(count), 0);

    // reset mid-operation
    bus.fu_ready = 3'b000;
    disp(6'd33, 6'd0, 1'b1, 32'h0, 6'd0, 1'b1, 32'h0, 3'b001);
    tick();
    idle();
    chk("mr_pre", 64'(count), 1);
    bus.fu_ready = 3'b111;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_iv", 64'(bus.issue_valid), 0);
    chk("mr_count", 64'(count), 0);
    chk("mr_rob", 64'(bus.issue_rob), 0);
    tick();
    chk("mr_iv2", 64'(bus.issue_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
